flow_ctrl_pipe: RTL and testbench
=================================

Name: flow_ctrl_pipe

Overview:
- Parametrised successor to the core's flush/stall/jump controller.
- Generalises to N pipeline stages, with multiple prioritised redirect sources and per-stage stall requests.
- Adds a registered pending-redirect that is held until the I-cache accepts it, plus saturating stall and flush performance counters.
- Sits between the pipeline stages and the per-stage pipeline registers, the PC generator and the I-cache.

Parameters:
- NUM_STAGES, 5, pipeline stages. Stage 0 is IF. Register j feeds stage j+1.
- NUM_REDIR, 2, redirect sources. Source k originates in stage k+REDIR_BASE. Higher k means an older stage and higher priority.
- REDIR_BASE, 1, stage of redirect source 0. NUM_REDIR+REDIR_BASE <= NUM_STAGES.
- PC_W, 32, PC width.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- stall_req_i  in  NUM_STAGES  bit s=1: stage s cannot advance. Bit 0 is the I-cache miss stall.
- redir_valid_i  in  NUM_REDIR  redirect request per source.
- redir_pc_i  in  NUM_REDIR*PC_W  target per source, source k at [k*PC_W +: PC_W].
- icache_ready_i  in  1  fetch accepts a redirect this cycle.
- cnt_clr_i  in  1  synchronous counter clear.
- pc_stall_o  out  1  hold PC.
- stall_o  out  NUM_STAGES-1  hold pipeline register j.
- flush_o  out  NUM_STAGES-1  load bubble into register j.
- jump_flag_o  out  1  redirect to fetch.
- jump_pc_o  out  PC_W  redirect target.
- stall_cnt_o  out  CNT_W  cycles with pc_stall_o=1.
- flush_cnt_o  out  CNT_W  accepted redirects.

Behaviour:
- Reset: pending valid=0, pending pc=0, pending source=0, both counters=0.
  - In reset all outputs are 0 except those driven by stall_req_i.
- hold_s = |stall_req_i[NUM_STAGES-1:s].
- Stall:
  - stall_o[j] = hold_(j+1).
  - pc_stall_o = hold_0.
  - Bubble: flush_o[s]=1 when stall_req_i[s]=1 and hold_(s+1)=0 (the top stage has no register above it).
- Redirect qualification:
  - Source k (stage s=k+REDIR_BASE) is eligible when redir_valid_i[k]=1 and hold_s=0.
  - The winner is the highest eligible k, called win.
  - With a pending redirect, win is accepted only if k > pending source. Otherwise it is ignored (wrong path).
- Accepted redirect from stage s:
  - flush_o[j]=1 and stall_o[j]=0 for all j<s; flush dominates stall.
  - pc_stall_o=0.
  - jump_flag_o=1 and jump_pc_o=win pc in the same cycle (combinational, zero latency).
- Pending:
  - If jump_flag_o=1 and icache_ready_i=0, the current target and source are registered as pending.
  - While pending is valid and there is no new accept: jump_flag_o=1, jump_pc_o=pending pc, flush_o[0]=1.
  - Pending clears on the clock edge where jump_flag_o=1 and icache_ready_i=1.
  - A higher-priority new accept overrides the pending target. If the I-cache is still not ready, the new target is registered.
- Idle: jump_flag_o=0 and jump_pc_o=0 when neither a new accept nor a pending redirect exists.
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at all-ones.
  - flush_cnt_o counts new accepts only, not pending-hold cycles.
  - cnt_clr_i takes priority over increment.
- Reset mid-pending: the pending redirect is dropped and counters are zeroed asynchronously.

Decomposition:
- Shared package holds:
  - stage index constants (STG_IF=0, STG_ID=1, STG_EX=2, STG_MEM=3, STG_WB=4);
  - default PC_W and CNT_W;
  - the reset PC-zero constant.
- One sub-module, flow_sat_counter (CNT_W, inc, clr, saturate), instantiated twice.

Test Plan:
- Stall only: stall_req_i=5'b00100 -> stall_o=4'b0011, flush_o=4'b0100, pc_stall_o=1. stall_cnt_o increments by 1 per cycle.
- Single redirect: redir_valid_i=2'b10 (EX), pc=0x8000_0040, icache_ready_i=1 -> same-cycle jump_flag_o=1, jump_pc_o=0x8000_0040, flush_o=4'b0011, flush_cnt_o=1.
- Priority: both sources valid, ID pc=0x100 and EX pc=0x200 -> jump_pc_o=0x200, flush_o[1:0]=2'b11. The ID source is ignored.
- Pending:
  - ID redirect to 0x300 with icache_ready_i=0 for 3 cycles -> jump_flag_o=1, jump_pc_o=0x300, flush_o[0]=1 in all 4 cycles.
  - Pending clears after the cycle in which ready=1. flush_cnt_o=1.
- Override and counters:
  - While an ID redirect to 0x300 is pending, an EX redirect to 0x400 -> jump_pc_o=0x400, which becomes the pending target.
  - A later ID redirect while 0x400 is pending is ignored.
  - Saturation: preload via 2^CNT_W stall cycles -> counter holds 0xFFFF. cnt_clr_i -> 0.
  - Async rst asserted mid-pending -> jump_flag_o=0 immediately.

Source files
------------

// File: rtl/flow_ctrl_pipe_pkg.sv
// Shared constants for the pipeline flow controller: stage indices, default widths, reset PC.
// Also holds a helper that sizes the pending-source index register.
package flow_ctrl_pipe_pkg;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam int DEF_PC_W  = 32;
  localparam int DEF_CNT_W = 16;

  localparam logic [DEF_PC_W-1:0] PC_ZERO = '0;

  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flow_sat_counter.sv
// Saturating event counter with synchronous clear that wins over increment.
// Latency: 1 cycle from inc to count; no backpressure, holds at all-ones.
module flow_sat_counter
  import flow_ctrl_pipe_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/flow_ctrl_pipe.sv
// N-stage stall/flush/redirect controller with a pending redirect held until the I-cache takes it.
// Latency: stall/flush/jump are combinational; pending redirect re-presented until icache_ready_i.
module flow_ctrl_pipe
  import flow_ctrl_pipe_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int NUM_REDIR  = 2,
  parameter int REDIR_BASE = 1,
  parameter int PC_W       = DEF_PC_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_STAGES-1:0]     stall_req_i,
  input  logic [NUM_REDIR-1:0]      redir_valid_i,
  input  logic [NUM_REDIR*PC_W-1:0] redir_pc_i,
  input  logic                      icache_ready_i,
  input  logic                      cnt_clr_i,
  output logic                      pc_stall_o,
  output logic [NUM_STAGES-2:0]     stall_o,
  output logic [NUM_STAGES-2:0]     flush_o,
  output logic                      jump_flag_o,
  output logic [PC_W-1:0]           jump_pc_o,
  output logic [CNT_W-1:0]          stall_cnt_o,
  output logic [CNT_W-1:0]          flush_cnt_o
);

  localparam int SRC_W = src_w(NUM_REDIR);

  logic [NUM_STAGES:0] hold;
  logic                any_elig;
  logic [SRC_W-1:0]    win_idx;
  logic [PC_W-1:0]     win_pc;
  logic                accept;

  logic                pend_vld;
  logic [PC_W-1:0]     pend_pc;
  logic [SRC_W-1:0]    pend_src;

  // hold[s]: some stage at or above s is stalled, so stage s cannot advance.
  always_comb begin
    hold = '0;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      hold[s] = hold[s+1] | stall_req_i[s];
    end
  end

  always_comb begin
    any_elig = 1'b0;
    win_idx  = '0;
    win_pc   = '0;
    for (int k = 0; k < NUM_REDIR; k++) begin
      if (redir_valid_i[k] && !hold[k+REDIR_BASE]) begin
        any_elig = 1'b1;
        win_idx  = SRC_W'(k);
        win_pc   = redir_pc_i[k*PC_W +: PC_W];
      end
    end
  end

  // Redirects arriving during reset are not acted on; a younger one behind a pending is wrong-path.
  assign accept = any_elig && !rst && (!pend_vld || (win_idx > pend_src));

  always_comb begin
    pc_stall_o  = hold[0];
    jump_flag_o = 1'b0;
    jump_pc_o   = '0;
    for (int j = 0; j < NUM_STAGES - 1; j++) begin
      stall_o[j] = hold[j+1];
      flush_o[j] = stall_req_i[j] & ~hold[j+1];
    end
    if (accept) begin
      pc_stall_o  = 1'b0;
      jump_flag_o = 1'b1;
      jump_pc_o   = win_pc;
      for (int j = 0; j < NUM_STAGES - 1; j++) begin
        if (j < int'(win_idx) + REDIR_BASE) begin
          flush_o[j] = 1'b1;
          stall_o[j] = 1'b0;
        end
      end
    end else if (pend_vld) begin
      jump_flag_o      = 1'b1;
      jump_pc_o        = pend_pc;
      flush_o[STG_IF]  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld <= 1'b0;
      pend_pc  <= PC_W'(PC_ZERO);
      pend_src <= '0;
    end else if (jump_flag_o) begin
      if (icache_ready_i) begin
        pend_vld <= 1'b0;
      end else begin
        pend_vld <= 1'b1;
        pend_pc  <= jump_pc_o;
        if (accept) begin
          pend_src <= win_idx;
        end
      end
    end
  end

  flow_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pc_stall_o),
    .clr (cnt_clr_i),
    .cnt (stall_cnt_o)
  );

  flow_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (accept),
    .clr (cnt_clr_i),
    .cnt (flush_cnt_o)
  );

endmodule

// File: tb/tb_flow_ctrl_pipe.sv
// Directed bench for flow_ctrl_pipe: stalls, redirects, priority, pending hold, counters, reset.
module tb_flow_ctrl_pipe;

  logic        clk;
  logic        rst;
  logic [4:0]  stall_req;
  logic [1:0]  redir_valid;
  logic [63:0] redir_pc;
  logic        icache_ready;
  logic        cnt_clr;
  logic        pc_stall;
  logic [3:0]  stall_o;
  logic [3:0]  flush_o;
  logic        jump_flag;
  logic [31:0] jump_pc;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  flow_ctrl_pipe dut (
    .clk            (clk),
    .rst            (rst),
    .stall_req_i    (stall_req),
    .redir_valid_i  (redir_valid),
    .redir_pc_i     (redir_pc),
    .icache_ready_i (icache_ready),
    .cnt_clr_i      (cnt_clr),
    .pc_stall_o     (pc_stall),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .jump_flag_o    (jump_flag),
    .jump_pc_o      (jump_pc),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_req = 5'b00100; redir_valid = 2'b00; redir_pc = '0;
    icache_ready = 1'b1; cnt_clr = 1'b0;
    #3;
    n_chk++; if (stall_o !== 4'b0011) begin n_fail++; $display("FAIL rst_stall_o got %b want 0011", stall_o); end
    n_chk++; if (flush_o !== 4'b0100) begin n_fail++; $display("FAIL rst_flush_o got %b want 0100", flush_o); end
    n_chk++; if (pc_stall !== 1'b1) begin n_fail++; $display("FAIL rst_pc_stall got %b want 1", pc_stall); end
    n_chk++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt); end
    n_chk++; if (flush_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_flush_cnt got %0d want 0", flush_cnt); end
    stall_req = 5'b00000; redir_valid = 2'b10; redir_pc = {32'h0000_1234, 32'h0};
    #1;
    n_chk++; if (jump_flag !== 1'b0) begin n_fail++; $display("FAIL rst_jump_flag got %b want 0", jump_flag); end
    n_chk++; if (jump_pc !== 32'h0) begin n_fail++; $display("FAIL rst_jump_pc got %h want 0", jump_pc); end
    n_chk++; if (flush_o !== 4'b0000) begin n_fail++; $display("FAIL rst_flush_idle got %b want 0000", flush_o); end
    redir_valid = 2'b00; redir_pc = '0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_stall_only();
    clr_cnt();
    stall_req = 5'b00100;
    #1;
    n_chk++; if (stall_o !== 4'b0011) begin n_fail++; $display("FAIL stall_stall_o got %b want 0011", stall_o); end
    n_chk++; if (flush_o !== 4'b0100) begin n_fail++; $display("FAIL stall_flush_o got %b want 0100", flush_o); end
    n_chk++; if (pc_stall !== 1'b1) begin n_fail++; $display("FAIL stall_pc_stall got %b want 1", pc_stall); end
    n_chk++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stall_cnt0 got %0d want 0", stall_cnt); end
    cyc();
    n_chk++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL stall_cnt1 got %0d want 1", stall_cnt); end
    cyc();
    n_chk++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL stall_cnt2 got %0d want 2", stall_cnt); end
    stall_req = 5'b00000;
    cyc();
    n_chk++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL stall_cnt_hold got %0d want 2", stall_cnt); end
    n_chk++; if (pc_stall !== 1'b0) begin n_fail++; $display("FAIL stall_release got %b want 0", pc_stall); end
    n_chk++; if (flush_cnt !== 16'd0) begin n_fail++; $display("FAIL stall_flush_cnt got %0d want 0", flush_cnt); end
  endtask

  task automatic test_single_redirect();
    clr_cnt();
    redir_valid = 2'b10; redir_pc = {32'h8000_0040, 32'h0}; icache_ready = 1'b1;
    #1;
    n_chk++; if (jump_flag !== 1'b1) begin n_fail++; $display("FAIL single_flag got %b want 1", jump_flag); end
    n_chk++; if (jump_pc !== 32'h8000_0040) begin n_fail++; $display("FAIL single_pc got %h want 80000040", jump_pc); end
    n_chk++; if (flush_o !== 4'b0011) begin n_fail++; $display("FAIL single_flush got %b want 0011", flush_o); end
    n_chk++; if (stall_o !== 4'b0000) begin n_fail++; $display("FAIL single_stall got %b want 0000", stall_o); end
    cyc();
    redir_valid = 2'b00; redir_pc = '0;
    #1;
    n_chk++; if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL single_flush_cnt got %0d want 1", flush_cnt); end
    n_chk++; if (jump_flag !== 1'b0) begin n_fail++; $display("FAIL single_idle_flag got %b want 0", jump_flag); end
    n_chk++; if (jump_pc !== 32'h0) begin n_fail++; $display("FAIL single_idle_pc got %h want 0", jump_pc); end
  endtask

  task automatic test_priority();
    clr_cnt();
    redir_valid = 2'b11; redir_pc = {32'h0000_0200, 32'h0000_0100}; icache_ready = 1'b1;
    #1;
    n_chk++; if (jump_pc !== 32'h0000_0200) begin n_fail++; $display("FAIL prio_pc got %h want 200", jump_pc); end
    n_chk++; if (flush_o[1:0] !== 2'b11) begin n_fail++; $display("FAIL prio_flush got %b want 11", flush_o[1:0]); end
    cyc();
    redir_valid = 2'b00; redir_pc = '0;
    #1;
    n_chk++; if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL prio_flush_cnt got %0d want 1", flush_cnt); end
  endtask

  task automatic test_pending();
    clr_cnt();
    redir_valid = 2'b01; redir_pc = {32'h0, 32'h0000_0300}; icache_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) begin
        redir_valid = 2'b00; redir_pc = '0;
      end
      icache_ready = (c == 4);
      #1;
      n_chk++; if (jump_flag !== 1'b1) begin n_fail++; $display("FAIL pend_flag c%0d got %b want 1", c, jump_flag); end
      n_chk++; if (jump_pc !== 32'h300) begin n_fail++; $display("FAIL pend_pc c%0d got %h want 300", c, jump_pc); end
      n_chk++; if (flush_o !== 4'b0001) begin n_fail++; $display("FAIL pend_flush c%0d got %b want 0001", c, flush_o); end
      cyc();
    end
    icache_ready = 1'b0;
    #1;
    n_chk++; if (jump_flag !== 1'b0) begin n_fail++; $display("FAIL pend_clear got %b want 0", jump_flag); end
    n_chk++; if (flush_o !== 4'b0000) begin n_fail++; $display("FAIL pend_clear_flush got %b want 0000", flush_o); end
    n_chk++; if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL pend_flush_cnt got %0d want 1", flush_cnt); end
  endtask

  task automatic test_override_and_reset();
    clr_cnt();
    redir_valid = 2'b01; redir_pc = {32'h0, 32'h0000_0300}; icache_ready = 1'b0;
    cyc();
    redir_valid = 2'b10; redir_pc = {32'h0000_0400, 32'h0};
    #1;
    n_chk++; if (jump_pc !== 32'h400) begin n_fail++; $display("FAIL ovr_pc got %h want 400", jump_pc); end
    n_chk++; if (flush_o !== 4'b0011) begin n_fail++; $display("FAIL ovr_flush got %b want 0011", flush_o); end
    cyc();
    redir_valid = 2'b01; redir_pc = {32'h0, 32'h0000_0500};
    #1;
    n_chk++; if (jump_pc !== 32'h400) begin n_fail++; $display("FAIL ovr_ignore_pc got %h want 400", jump_pc); end
    n_chk++; if (flush_o !== 4'b0001) begin n_fail++; $display("FAIL ovr_ignore_flush got %b want 0001", flush_o); end
    cyc();
    redir_valid = 2'b00; redir_pc = '0;
    #1;
    n_chk++; if (jump_pc !== 32'h400) begin n_fail++; $display("FAIL ovr_held_pc got %h want 400", jump_pc); end
    n_chk++; if (flush_cnt !== 16'd2) begin n_fail++; $display("FAIL ovr_flush_cnt got %0d want 2", flush_cnt); end
    #1;
    rst = 1'b1;
    #1;
    n_chk++; if (jump_flag !== 1'b0) begin n_fail++; $display("FAIL arst_flag got %b want 0", jump_flag); end
    n_chk++; if (flush_cnt !== 16'd0) begin n_fail++; $display("FAIL arst_flush_cnt got %0d want 0", flush_cnt); end
    #1;
    rst = 1'b0;
    cyc();
    n_chk++; if (jump_flag !== 1'b0) begin n_fail++; $display("FAIL arst_dropped got %b want 0", jump_flag); end
  endtask

  task automatic test_saturation();
    clr_cnt();
    stall_req = 5'b00001;
    repeat (65535) cyc();
    n_chk++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got %h want ffff", stall_cnt); end
    repeat (5) cyc();
    n_chk++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h want ffff", stall_cnt); end
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    n_chk++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL sat_clr got %h want 0", stall_cnt); end
    cyc();
    n_chk++; if (stall_cnt !== 16'h1) begin n_fail++; $display("FAIL sat_after_clr got %h want 1", stall_cnt); end
    stall_req = 5'b00000;
  endtask

  initial begin
    test_reset();
    test_stall_only();
    test_single_redirect();
    test_priority();
    test_pending();
    test_override_and_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
